// File: rtl/mmio_port_pkg.sv
// mmio_port_pkg -- shared definitions for the memory-mapped switch/display/timer port.
// Holds the register addresses and STAT bit positions. The CPU top imports this
// package as well, so both sides of the bus agree on the map.
package mmio_port_pkg;

  localparam int ADDR_RELOAD = 28;
  localparam int ADDR_STAT   = 29;
  localparam int ADDR_DISP   = 30;
  localparam int ADDR_SW     = 31;

  localparam int STAT_CHG = 0;
  localparam int STAT_TMR = 1;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_RELOAD,
    REG_STAT,
    REG_DISP,
    REG_SW
  } reg_sel_e;

endpackage

// File: rtl/mmio_port_debouncer.sv
// debouncer -- synchronizes and debounces a word of raw board switches.
// Ports:
//   clock, n_reset : system clock, async active-low reset
//   raw            : asynchronous switch inputs
//   deb            : debounced value
//   change         : high in the clock whose edge updates deb
// The 2-flop synchronizer output must differ from deb and stay constant for
// DEB_N clocks before deb follows it. A clean edge reaches deb 2+DEB_N clocks
// after it was applied.
module debouncer #(
  parameter int WORD_W = 8,
  parameter int DEB_N  = 4
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic [WORD_W-1:0] raw,
  output logic [WORD_W-1:0] deb,
  output logic              change
);
  import mmio_port_pkg::*;

  localparam int CW = (DEB_N > 1) ? $clog2(DEB_N + 1) : 1;

  logic [WORD_W-1:0] sync1;
  logic [WORD_W-1:0] sync2;
  logic [WORD_W-1:0] prev;
  logic [CW-1:0]     cnt;
  logic              moved;
  logic              done;

  // moved: sync2 took a new value this clock, so it has been stable for one clock.
  // Otherwise cnt+1 clocks of stability have been observed.
  assign moved  = (sync2 != prev);
  assign done   = (sync2 != deb) && (moved ? (DEB_N == 1) : (cnt == CW'(DEB_N - 1)));
  assign change = done;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      cnt   <= '0;
      deb   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      prev  <= sync2;
      if (sync2 == deb || done)
        cnt <= '0;
      else if (moved)
        cnt <= CW'(1);
      else
        cnt <= cnt + CW'(1);
      if (done)
        deb <= sync2;
    end
  end

endmodule

// File: rtl/mmio_port.sv
// mmio_port -- memory-mapped I/O block: debounced switches, display register,
// status flags and a prescaled reload timer.
// Ports:
//   clock, n_reset : system clock, async active-low reset
//   Daddress       : CPU data address (WORD_W-OP_W bits)
//   Wdata, WE      : CPU write data and one-clock write strobe
//   RD             : one-clock read strobe, used only for read side effects
//   switches       : raw board switches
//   sel            : Daddress falls in 28..31
//   Pdata          : combinational read data, 0 when not selected
//   digits         : display register to the seven-segment decoders
// Map: 31 SW (ro), 30 DISP, 29 STAT {TMR, CHG}, 28 RELOAD.
module mmio_port #(
  parameter int WORD_W   = 8,
  parameter int OP_W     = 3,
  parameter int DEB_N    = 4,
  parameter int PRESCALE = 16
) (
  input  logic                   clock,
  input  logic                   n_reset,
  input  logic [WORD_W-OP_W-1:0] Daddress,
  input  logic [WORD_W-1:0]      Wdata,
  input  logic                   WE,
  input  logic                   RD,
  input  logic [WORD_W-1:0]      switches,
  output logic                   sel,
  output logic [WORD_W-1:0]      Pdata,
  output logic [WORD_W-1:0]      digits
);
  import mmio_port_pkg::*;

  localparam int AW = WORD_W - OP_W;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [AW-1:0] A_RELOAD = AW'(ADDR_RELOAD);
  localparam logic [AW-1:0] A_STAT   = AW'(ADDR_STAT);
  localparam logic [AW-1:0] A_DISP   = AW'(ADDR_DISP);
  localparam logic [AW-1:0] A_SW     = AW'(ADDR_SW);

  reg_sel_e          reg_sel;
  logic [WORD_W-1:0] sw_deb;
  logic              sw_change;
  logic [WORD_W-1:0] disp;
  logic [WORD_W-1:0] reload;
  logic [WORD_W-1:0] count;
  logic [PW-1:0]     pre;
  logic              chg;
  logic              tmr;

  logic wr_disp, wr_reload, wr_stat;
  logic tick, tmr_set, clr_chg, clr_tmr;

  debouncer #(
    .WORD_W (WORD_W),
    .DEB_N  (DEB_N)
  ) u_debouncer (
    .clock   (clock),
    .n_reset (n_reset),
    .raw     (switches),
    .deb     (sw_deb),
    .change  (sw_change)
  );

  always_comb begin
    reg_sel = REG_NONE;
    case (Daddress)
      A_RELOAD: reg_sel = REG_RELOAD;
      A_STAT:   reg_sel = REG_STAT;
      A_DISP:   reg_sel = REG_DISP;
      A_SW:     reg_sel = REG_SW;
      default:  reg_sel = REG_NONE;
    endcase
  end

  assign sel = (reg_sel != REG_NONE);

  always_comb begin
    Pdata = '0;
    case (reg_sel)
      REG_SW:     Pdata = sw_deb;
      REG_DISP:   Pdata = disp;
      REG_RELOAD: Pdata = reload;
      REG_STAT: begin
        Pdata[STAT_CHG] = chg;
        Pdata[STAT_TMR] = tmr;
      end
      default:    Pdata = '0;
    endcase
  end

  assign digits = disp;

  assign wr_disp   = WE && (reg_sel == REG_DISP);
  assign wr_reload = WE && (reg_sel == REG_RELOAD);
  assign wr_stat   = WE && (reg_sel == REG_STAT);

  assign tick = (pre == PW'(PRESCALE - 1));
  // A RELOAD write on the tick edge takes precedence over the tick.
  assign tmr_set = tick && !wr_reload && (count == WORD_W'(1));
  assign clr_tmr = wr_stat && Wdata[STAT_TMR];
  assign clr_chg = (wr_stat && Wdata[STAT_CHG]) || (RD && (reg_sel == REG_SW));

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      disp   <= '0;
      reload <= '0;
      count  <= '0;
      pre    <= '0;
      chg    <= 1'b0;
      tmr    <= 1'b0;
    end else begin
      if (wr_disp)
        disp <= Wdata;

      if (wr_reload || tick)
        pre <= '0;
      else
        pre <= pre + PW'(1);

      // count == 0 only when RELOAD is 0, which holds the timer idle.
      if (wr_reload) begin
        reload <= Wdata;
        count  <= Wdata;
      end else if (tick && count != '0) begin
        if (count == WORD_W'(1))
          count <= reload;
        else
          count <= count - WORD_W'(1);
      end

      if (sw_change)
        chg <= 1'b1;
      else if (clr_chg)
        chg <= 1'b0;

      if (tmr_set)
        tmr <= 1'b1;
      else if (clr_tmr)
        tmr <= 1'b0;
    end
  end

endmodule

// File: doc/mmio_port.md
MMIO_PORT -- requirements
Module: mmio_port

Interface
REQ-001 Parameters SHALL be: WORD_W, default 8, data word width; OP_W, default 3, opcode width (address width = WORD_W-OP_W); DEB_N, default 4, debounce stability count in clocks; PRESCALE, default 16, clocks per timer tick.
REQ-002 Ports SHALL be, clock and reset first:
- clock  input  1  single system clock, rising edge
- n_reset  input  1  asynchronous, active-low reset
- Daddress  input  WORD_W-OP_W  data address from CPU
- Wdata  input  WORD_W  write data from CPU
- WE  input  1  write strobe, one clock
- RD  input  1  read strobe, one clock, used only for read side effects
- switches  input  WORD_W  raw, asynchronous board switches
- sel  output  1  Daddress hits this block (addresses 28..31)
- Pdata  output  WORD_W  read data for the addressed register
- digits  output  WORD_W  display register, drives the two seven-segment decoders
REQ-003 The block SHALL use one clock, clock; reset SHALL be n_reset, asynchronous and active-low.

Function
REQ-004 Address map SHALL be: 31 SW (read-only, debounced switches); 30 DISP (read/write); 29 STAT (bit0 CHG, bit1 TMR, bits 7:2 read 0); 28 RELOAD (read/write).
REQ-005 sel SHALL equal 1 iff Daddress >= 28; Pdata SHALL be combinational from Daddress and SHALL be 0 when sel=0.
REQ-006 switches SHALL pass through a 2-flop synchronizer before any other use.
REQ-007 The debounced value SHALL take the synchronized value once that value has differed from it and stayed constant for DEB_N consecutive clocks; any change within the window SHALL restart the count.
REQ-008 Switch edge-to-SW latency SHALL be exactly 2+DEB_N clocks for a clean edge.
REQ-009 CHG SHALL set in the clock in which the debounced value changes; it SHALL clear on RD with Daddress=31.
REQ-010 Write with Daddress=30 SHALL load DISP from Wdata on that edge; digits SHALL equal DISP.
REQ-011 Write with Daddress=28 SHALL load RELOAD and the timer count, and SHALL restart the prescaler at 0.
REQ-012 Prescaler SHALL count 0..PRESCALE-1 and wrap; each wrap SHALL be one tick.
REQ-013 On a tick with count>1 the count SHALL decrement; with count=1 the count SHALL reload from RELOAD and TMR SHALL set.
REQ-014 RELOAD=0 SHALL disable the timer: count held at 0, no ticks affect TMR.
REQ-015 Write with Daddress=29 SHALL clear TMR if Wdata[1]=1 and CHG if Wdata[0]=1; other bits ignored.
REQ-016 When a set and a clear of the same flag occur in one clock, set SHALL win.
REQ-017 Writes to 31 and reads with side effects at 28..30 SHALL have no effect; WE and RD asserted together SHALL both take effect.

Reset
REQ-018 n_reset low SHALL immediately clear DISP, RELOAD, timer count, prescaler, CHG, TMR, synchronizer flops, debounced value and debounce counter; digits SHALL read 0.
REQ-019 Reset asserted mid-debounce or mid-countdown SHALL abandon the operation; no flag SHALL set on reset release.
REQ-020 Switches nonzero at reset release SHALL appear in SW after 2+DEB_N clocks and SHALL set CHG.

Structure
REQ-021 Address constants (28..31) and STAT bit positions SHALL live in a shared package imported by mmio_port and the CPU top.
REQ-022 Synchronizer plus debounce logic SHALL be one sub-module, debouncer, parameterised by WORD_W and DEB_N.

Verification
REQ-023 switches 0x00->0xA5 clean, DEB_N=4 -> SW=0xA5 exactly 6 clocks later, CHG=1 in that same clock.
REQ-024 switches toggle 0x01/0x00 every 3 clocks for 20 clocks -> SW stays 0x00, CHG stays 0.
REQ-025 WE, Daddress=30, Wdata=0x3C -> digits=0x3C next clock; read 30 gives Pdata=0x3C.
REQ-026 Write RELOAD=2, PRESCALE=16 -> TMR sets 32 clocks after write, again 32 later; write STAT 0x02 -> TMR=0.
REQ-027 Write STAT 0x02 in the tick clock where TMR sets -> TMR=1 (set wins); RD at 31 in the CHG set clock -> CHG=1.
REQ-028 n_reset low mid-countdown with DISP=0xFF -> digits=0x00 before next edge, TMR=0, no timer activity until RELOAD rewritten.
